// File: rtl/mips_mem_pkg.sv
// -----------------------------------------------------------------------------
// mips_mem_pkg
// Shared definitions for the data-RAM address translators (forward and
// readback):
//   - MIPS_DATA_BASE : MIPS virtual address of data-RAM word 0
//   - DATA_RAM_DEPTH : default number of data-RAM words
//   - state_t        : readback FSM encoding (IDLE, RD, WT, PR, ERR, FIN)
//   - index_to_vaddr / vaddr_to_index : 32-bit word-index <-> virtual address
// -----------------------------------------------------------------------------
package mips_mem_pkg;

  localparam logic [31:0] MIPS_DATA_BASE = 32'h1001_0000;
  localparam int          DATA_RAM_DEPTH = 256;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WT   = 3'd2,
    PR   = 3'd3,
    ERR  = 3'd4,
    FIN  = 3'd5
  } state_t;

  // Word index -> byte-addressed MIPS virtual address.
  function automatic logic [31:0] index_to_vaddr(input logic [31:0] idx);
    return (idx << 2) + MIPS_DATA_BASE;
  endfunction

  // MIPS virtual address -> word index (caller checks alignment and range).
  function automatic logic [31:0] vaddr_to_index(input logic [31:0] vaddr);
    return (vaddr - MIPS_DATA_BASE) >> 2;
  endfunction

endpackage

// File: rtl/mips_index_to_vaddr.sv
// -----------------------------------------------------------------------------
// mips_index_to_vaddr
// Combinational conversion of a data-RAM word index into its MIPS virtual
// address: vaddr = (idx << 2) + BASE_ADDR.
// Ports:
//   idx   in  IDX_WIDTH   word index
//   vaddr out ADDR_WIDTH  MIPS virtual byte address
// -----------------------------------------------------------------------------
module mips_index_to_vaddr #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    IDX_WIDTH  = 9,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(32'h1001_0000)
) (
  input  logic [IDX_WIDTH-1:0]  idx,
  output logic [ADDR_WIDTH-1:0] vaddr
);

  assign vaddr = (ADDR_WIDTH'(idx) << 2) + BASE_ADDR;

endmodule

// File: rtl/data_mem_readback.sv
// -----------------------------------------------------------------------------
// data_mem_readback
// Walks data-RAM words starting at a MIPS virtual address, issuing
// synchronous reads on the RAM's second read port and streaming
// (virtual address, data) pairs to the debug dump / UART inspection path.
//
// Ports:
//   clk, reset (async, active-low)
//   start, start_addr, word_count     : run request (sampled only in IDLE)
//   ram_rd_en, ram_addr, ram_rdata    : RAM read port (data 1 cycle after rd_en)
//   out_valid/out_ready, out_mips_addr, out_data, out_last : output stream
//   busy, done, error                 : run status
//   checksum (only with DATA_MEM_READBACK_CHECKSUM_EN) : sum of delivered words
//   fsm_state                         : current FSM state, for observation
//
// Output handshake: a pair transfers on a rising edge where out_valid and
// out_ready are both high. out_valid never depends on out_ready, and the
// pair (address, data, last) is held stable from out_valid rising until that
// transfer. out_ready while out_valid is low is ignored.
//
// Optional feature macro: DATA_MEM_READBACK_CHECKSUM_EN adds the checksum
// output and its accumulator.
// -----------------------------------------------------------------------------
module data_mem_readback
  import mips_mem_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    RAM_DEPTH  = DATA_RAM_DEPTH,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(MIPS_DATA_BASE),
  parameter int                    CNT_WIDTH  = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [CNT_WIDTH-1:0]  word_count,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_mips_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
`ifdef DATA_MEM_READBACK_CHECKSUM_EN
  output logic [DATA_WIDTH-1:0] checksum,
`endif
  output state_t                fsm_state
);

  state_t                state, state_next;
  logic [CNT_WIDTH-1:0]  idx;
  logic [CNT_WIDTH-1:0]  remaining;
  logic [ADDR_WIDTH-1:0] idx_vaddr;

  // Request decode. One extra bit so neither the subtraction nor the
  // idx0 + word_count sum can wrap into a false "in range".
  logic [ADDR_WIDTH:0] offset;
  logic [ADDR_WIDTH:0] idx0_wide;
  logic [ADDR_WIDTH:0] end_wide;
  logic                misaligned;
  logic                below_base;
  logic                overrun;
  logic                bad_req;

  always_comb begin
    offset     = {1'b0, start_addr} - {1'b0, BASE_ADDR};
    idx0_wide  = offset >> 2;
    end_wide   = idx0_wide + (ADDR_WIDTH+1)'(word_count);
    misaligned = (start_addr[1:0] != 2'b00);
    below_base = (start_addr < BASE_ADDR);
    overrun    = (end_wide > (ADDR_WIDTH+1)'(RAM_DEPTH));
    bad_req    = misaligned | below_base | overrun;
  end

  mips_index_to_vaddr #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .IDX_WIDTH  (CNT_WIDTH),
    .BASE_ADDR  (BASE_ADDR)
  ) u_idx_to_vaddr (
    .idx   (idx),
    .vaddr (idx_vaddr)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (bad_req)                          state_next = ERR;
          else if (word_count == '0)            state_next = FIN;
          else                                  state_next = RD;
        end
      end
      RD:  state_next = WT;
      WT:  state_next = PR;
      PR:  begin
        if (out_ready) state_next = out_last ? FIN : RD;
      end
      ERR: state_next = FIN;
      FIN: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx           <= '0;
      remaining     <= '0;
      out_data      <= '0;
      out_mips_addr <= '0;
      out_last      <= 1'b0;
      error         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            error     <= 1'b0;
            idx       <= idx0_wide[CNT_WIDTH-1:0];
            remaining <= word_count;
          end
        end
        WT: begin
          out_data      <= ram_rdata;
          out_mips_addr <= idx_vaddr;
          out_last      <= (remaining == CNT_WIDTH'(1));
        end
        PR: begin
          if (out_ready) begin
            idx       <= idx + CNT_WIDTH'(1);
            remaining <= remaining - CNT_WIDTH'(1);
          end
        end
        ERR:     error <= 1'b1;
        default: ;
      endcase
    end
  end

`ifdef DATA_MEM_READBACK_CHECKSUM_EN
  // Sum of words actually handed over; an error run never reaches PR so the
  // sum stays at the zero loaded by the accepted start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      checksum <= '0;
    end else if (state == IDLE && start) begin
      checksum <= '0;
    end else if (state == PR && out_ready) begin
      checksum <= checksum + out_data;
    end
  end
`endif

  // State-decoded outputs. ram_addr is only driven during RD so the index,
  // which steps past the last word after the final handshake, never appears.
  always_comb begin
    ram_rd_en = (state == RD);
    ram_addr  = (state == RD) ? ADDR_WIDTH'(idx) : '0;
    out_valid = (state == PR);
    busy      = (state != IDLE);
    done      = (state == FIN);
    fsm_state = state;
  end

endmodule

// File: tb/tb_data_mem_readback.sv
// -----------------------------------------------------------------------------
// tb_data_mem_readback
// Self-checking bench for data_mem_readback: behavioural RAM model, a
// scoreboard of expected (address, data, last) pairs, scenario tasks and a
// final summary line.
// -----------------------------------------------------------------------------
module tb_data_mem_readback;
  import mips_mem_pkg::*;

  localparam int          AW    = 32;
  localparam int          DW    = 32;
  localparam int          CW    = 9;
  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h1001_0000;

  logic          clk;
  logic          reset;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [CW-1:0] word_count;
  logic          ram_rd_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_mips_addr;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;
  logic          error;
`ifdef DATA_MEM_READBACK_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif
  state_t        fsm_state;

  data_mem_readback dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .start_addr    (start_addr),
    .word_count    (word_count),
    .ram_rd_en     (ram_rd_en),
    .ram_addr      (ram_addr),
    .ram_rdata     (ram_rdata),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_mips_addr (out_mips_addr),
    .out_data      (out_data),
    .out_last      (out_last),
    .busy          (busy),
    .done          (done),
    .error         (error),
`ifdef DATA_MEM_READBACK_CHECKSUM_EN
    .checksum      (checksum),
`endif
    .fsm_state     (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- RAM model ----------------
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_rd_en) ram_rdata <= mem[ram_addr[7:0]];
  end

  // ---------------- scoreboard ----------------
  logic [AW+DW:0] exp_q[$];
  logic [DW-1:0]  exp_sum;
  int tests = 0;
  int fails = 0;
  int rd_cnt = 0, done_cnt = 0, valid_cnt = 0, hs_cnt = 0;
  int first_valid_cyc = -1;
  int last_hs_cyc = 0;
  int start_cyc = 0;
  int done_cyc = 0;

  always @(negedge clk) begin
    logic [AW+DW:0] e;
    if (done) done_cnt++;
    if (ram_rd_en) begin
      rd_cnt++;
      tests++;
      if (ram_addr >= AW'(DEPTH)) begin
        fails++;
        $display("FAIL ram_addr_range: got %0d, need < %0d", ram_addr, DEPTH);
      end
    end
    if (out_valid) begin
      valid_cnt++;
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
    end
    if (out_valid && out_ready) begin
      hs_cnt++;
      last_hs_cyc = cyc;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL pair_unexpected: got addr=%h data=%h last=%0b, need no pair",
                 out_mips_addr, out_data, out_last);
      end else begin
        e = exp_q.pop_front();
        if ({out_mips_addr, out_data, out_last} !== e) begin
          fails++;
          $display("FAIL pair: got addr=%h data=%h last=%0b, need addr=%h data=%h last=%0b",
                   out_mips_addr, out_data, out_last, e[AW+DW:DW+1], e[DW:1], e[0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_run(input int idx, input int cnt);
    exp_sum = '0;
    for (int k = 0; k < cnt; k++) begin
      exp_q.push_back({BASE + 32'((idx + k) * 4), mem[idx + k], (k == cnt - 1)});
      exp_sum = exp_sum + mem[idx + k];
    end
  endtask

  task automatic do_start(input logic [AW-1:0] a, input logic [CW-1:0] c);
    @(posedge clk); #1;
    start = 1'b1; start_addr = a; word_count = c;
    start_cyc = cyc;
    first_valid_cyc = -1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rand_ready, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        done_cyc = cyc;
        break;
      end
      @(posedge clk); #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL %s_timeout: no done within %0d cycles", name, budget);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0; start = 1'b0; start_addr = '0; word_count = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    tests += 9;
    if (ram_rd_en !== 1'b0)  begin fails++; $display("FAIL reset_rd_en: got %b, need 0", ram_rd_en); end
    if (ram_addr !== '0)     begin fails++; $display("FAIL reset_ram_addr: got %h, need 0", ram_addr); end
    if (out_valid !== 1'b0)  begin fails++; $display("FAIL reset_out_valid: got %b, need 0", out_valid); end
    if (out_mips_addr !== '0) begin fails++; $display("FAIL reset_out_addr: got %h, need 0", out_mips_addr); end
    if (out_data !== '0)     begin fails++; $display("FAIL reset_out_data: got %h, need 0", out_data); end
    if (out_last !== 1'b0)   begin fails++; $display("FAIL reset_out_last: got %b, need 0", out_last); end
    if (busy !== 1'b0)       begin fails++; $display("FAIL reset_busy: got %b, need 0", busy); end
    if (done !== 1'b0)       begin fails++; $display("FAIL reset_done: got %b, need 0", done); end
    if (error !== 1'b0)      begin fails++; $display("FAIL reset_error: got %b, need 0", error); end
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_basic();
    int rd0;
    mem[0] = 32'hAAAA_0001; mem[1] = 32'hBBBB_0002; mem[2] = 32'hCCCC_0003;
    out_ready = 1'b1;
    rd0 = rd_cnt;
    push_run(0, 3);
    do_start(BASE, 3);
    wait_done(40, 1'b0, "basic");
    tests += 5;
    if (first_valid_cyc - start_cyc != 3) begin fails++; $display("FAIL basic_latency: got %0d, need 3", first_valid_cyc - start_cyc); end
    if (done_cyc != last_hs_cyc + 1) begin fails++; $display("FAIL basic_done_timing: got %0d, need %0d", done_cyc, last_hs_cyc + 1); end
    if (rd_cnt - rd0 != 3) begin fails++; $display("FAIL basic_reads: got %0d, need 3", rd_cnt - rd0); end
    if (exp_q.size() != 0) begin fails++; $display("FAIL basic_pairs_left: got %0d, need 0", exp_q.size()); end
    if (error !== 1'b0) begin fails++; $display("FAIL basic_error: got %b, need 0", error); end
`ifdef DATA_MEM_READBACK_CHECKSUM_EN
    tests++;
    if (checksum !== exp_sum) begin fails++; $display("FAIL basic_checksum: got %h, need %h", checksum, exp_sum); end
`endif
  endtask

  task automatic test_misaligned();
    int rd0, v0, d0;
    rd0 = rd_cnt; v0 = valid_cnt; d0 = done_cnt;
    do_start(BASE + 32'h6, 1);
    wait_done(10, 1'b0, "misaligned");
    tests += 4;
    if (rd_cnt != rd0) begin fails++; $display("FAIL misaligned_reads: got %0d, need 0", rd_cnt - rd0); end
    if (valid_cnt != v0) begin fails++; $display("FAIL misaligned_valid: got %0d, need 0", valid_cnt - v0); end
    if (error !== 1'b1) begin fails++; $display("FAIL misaligned_error: got %b, need 1", error); end
    if (done_cnt - d0 != 1) begin fails++; $display("FAIL misaligned_done: got %0d pulses, need 1", done_cnt - d0); end
`ifdef DATA_MEM_READBACK_CHECKSUM_EN
    tests++;
    if (checksum !== '0) begin fails++; $display("FAIL misaligned_checksum: got %h, need 0", checksum); end
`endif
  endtask

  task automatic test_top_word();
    int rd0, v0;
    rd0 = rd_cnt;
    push_run(255, 1);
    do_start(32'h1001_03FC, 1);
    tests++;
    if (error !== 1'b0) begin fails++; $display("FAIL error_clear_on_start: got %b, need 0", error); end
    wait_done(20, 1'b0, "top_word");
    tests += 2;
    if (rd_cnt - rd0 != 1) begin fails++; $display("FAIL top_word_reads: got %0d, need 1", rd_cnt - rd0); end
    if (exp_q.size() != 0) begin fails++; $display("FAIL top_word_pairs_left: got %0d, need 0", exp_q.size()); end
    rd0 = rd_cnt; v0 = valid_cnt;
    do_start(32'h1001_03FC, 2);
    wait_done(10, 1'b0, "overrun");
    tests += 3;
    if (rd_cnt != rd0) begin fails++; $display("FAIL overrun_reads: got %0d, need 0", rd_cnt - rd0); end
    if (valid_cnt != v0) begin fails++; $display("FAIL overrun_valid: got %0d, need 0", valid_cnt - v0); end
    if (error !== 1'b1) begin fails++; $display("FAIL overrun_error: got %b, need 1", error); end
  endtask

  task automatic test_zero_count();
    int rd0, v0, d0;
    rd0 = rd_cnt; v0 = valid_cnt; d0 = done_cnt;
    do_start(BASE + 32'h40, 0);
    wait_done(6, 1'b0, "zero_count");
    tests += 5;
    if (done_cyc - start_cyc < 1 || done_cyc - start_cyc > 2) begin fails++; $display("FAIL zero_done_timing: got %0d, need 1..2", done_cyc - start_cyc); end
    if (error !== 1'b0) begin fails++; $display("FAIL zero_error: got %b, need 0", error); end
    if (rd_cnt != rd0) begin fails++; $display("FAIL zero_reads: got %0d, need 0", rd_cnt - rd0); end
    if (valid_cnt != v0) begin fails++; $display("FAIL zero_valid: got %0d, need 0", valid_cnt - v0); end
    if (done_cnt - d0 != 1) begin fails++; $display("FAIL zero_done_count: got %0d, need 1", done_cnt - d0); end
  endtask

  task automatic test_stall();
    int rd0, rd_stall;
    bit seen;
    logic [AW+DW:0] e;
    out_ready = 1'b0;
    rd0 = rd_cnt;
    push_run(10, 2);
    do_start(BASE + 32'd40, 2);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1'b1; break; end
    end
    tests++;
    if (!seen) begin fails++; $display("FAIL stall_valid_timeout: got none, need out_valid"); end
    rd_stall = rd_cnt;
    e = exp_q[0];
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      start = (k == 1);
      start_addr = BASE + 32'h2;
      word_count = 1;
      @(negedge clk);
      tests += 3;
      if (out_valid !== 1'b1) begin fails++; $display("FAIL stall_valid: got %b, need 1", out_valid); end
      if ({out_mips_addr, out_data, out_last} !== e) begin fails++; $display("FAIL stall_hold: got addr=%h data=%h, need addr=%h data=%h", out_mips_addr, out_data, e[AW+DW:DW+1], e[DW:1]); end
      if (rd_cnt != rd_stall) begin fails++; $display("FAIL stall_extra_read: got %0d, need %0d", rd_cnt, rd_stall); end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_done(30, 1'b0, "stall");
    tests += 3;
    if (exp_q.size() != 0) begin fails++; $display("FAIL stall_pairs_left: got %0d, need 0", exp_q.size()); end
    if (error !== 1'b0) begin fails++; $display("FAIL stall_error: got %b, need 0", error); end
    if (rd_cnt - rd0 != 2) begin fails++; $display("FAIL stall_reads: got %0d, need 2", rd_cnt - rd0); end
  endtask

  task automatic test_random();
    int idx, cnt;
    for (int r = 0; r < 4; r++) begin
      idx = $urandom_range(0, 250);
      cnt = $urandom_range(1, 6);
      push_run(idx, cnt);
      do_start(BASE + 32'(idx * 4), CW'(cnt));
      wait_done(300, 1'b1, "random");
      tests += 2;
      if (exp_q.size() != 0) begin fails++; $display("FAIL random_pairs_left: got %0d, need 0", exp_q.size()); end
      if (error !== 1'b0) begin fails++; $display("FAIL random_error: got %b, need 0", error); end
`ifdef DATA_MEM_READBACK_CHECKSUM_EN
      tests++;
      if (checksum !== exp_sum) begin fails++; $display("FAIL random_checksum: got %h, need %h", checksum, exp_sum); end
`endif
    end
  endtask

  task automatic test_reset_mid_run();
    int h0, d0;
    bit reached;
    out_ready = 1'b1;
    h0 = hs_cnt;
    push_run(0, 6);
    do_start(BASE, 6);
    reached = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (hs_cnt - h0 >= 2) begin reached = 1'b1; break; end
    end
    tests++;
    if (!reached) begin fails++; $display("FAIL midrun_timeout: got %0d pairs, need 2", hs_cnt - h0); end
    d0 = done_cnt;
    reset = 1'b0;
    #1;
    tests++;
    if ({ram_rd_en, ram_addr, out_valid, out_mips_addr, out_data, out_last, busy, done, error} !== '0) begin
      fails++;
      $display("FAIL midrun_outputs: got rd=%b ra=%h v=%b a=%h d=%h l=%b busy=%b done=%b err=%b, need all 0",
               ram_rd_en, ram_addr, out_valid, out_mips_addr, out_data, out_last, busy, done, error);
    end
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    tests++;
    if (done_cnt != d0) begin fails++; $display("FAIL midrun_done: got %0d pulses, need 0", done_cnt - d0); end
    push_run(4, 1);
    do_start(BASE + 32'h10, 1);
    wait_done(20, 1'b0, "after_reset");
    tests += 2;
    if (exp_q.size() != 0) begin fails++; $display("FAIL after_reset_pairs_left: got %0d, need 0", exp_q.size()); end
    if (error !== 1'b0) begin fails++; $display("FAIL after_reset_error: got %b, need 0", error); end
`ifdef DATA_MEM_READBACK_CHECKSUM_EN
    tests++;
    if (checksum !== exp_sum) begin fails++; $display("FAIL after_reset_checksum: got %h, need %h", checksum, exp_sum); end
`endif
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    ram_rdata = '0;
    test_reset();
    test_basic();
    test_misaligned();
    test_top_word();
    test_zero_count();
    test_stall();
    test_random();
    test_reset_mid_run();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
